// File: rtl/neighbor_cluster_scanner.sv
// neighbor_cluster_scanner
//   Bus initiator for the 2048-byte node table. On start it reads the
//   neighbor count and each neighbor's ID and cluster ID. Every neighbor
//   whose cluster differs from the latched own cluster is appended to the
//   betterneighbors list (capacity 16). The final count is then written to
//   betterneighborCount.
//
// Ports
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   start           : scan request, only looked at in IDLE
//   my_cluster_id   : own cluster ID, latched when start is accepted
//   mem_addr        : byte address (16-bit big-endian word port)
//   mem_wr_en       : write strobe, commits at the edge ending the cycle
//   mem_wdata       : write word
//   mem_rdata       : combinational read word for mem_addr
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse in the DONE state
//   match_count     : entries written by the current / last scan
//   overflow        : a matching neighbor was dropped (list full)
//   dbg_state       : current FSM state encoding
//
// Handshake: start is a level sampled only in IDLE; one cycle of start in
// IDLE launches exactly one scan, start while busy is ignored and never
// queued. done marks the single cycle after the count word was committed.
module neighbor_cluster_scanner #(
    parameter logic [15:0] NB_COUNT_ADDR  = 16'h068A,
    parameter logic [15:0] NB_ID_BASE     = 16'h0048,
    parameter logic [15:0] CL_ID_BASE     = 16'h00C8,
    parameter logic [15:0] OUT_BASE       = 16'h0668,
    parameter logic [15:0] OUT_COUNT_ADDR = 16'h068C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] my_cluster_id,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [4:0]  match_count,
    output logic        overflow,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_NCOUNT = 3'd1,
        S_RD_NID    = 3'd2,
        S_RD_CID    = 3'd3,
        S_WR_ENTRY  = 3'd4,
        S_WR_COUNT  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_my_cl;
    logic [15:0] r_id;
    logic [6:0]  r_n;
    logic [6:0]  r_i;
    logic [4:0]  r_k;
    logic        r_overflow;

    logic [6:0]  w_clamped_n;
    logic        w_last;
    logic        w_differ;
    logic        w_full;

    // Neighbor count is clamped to 64 so the table reads never run past
    // the clusterID array.
    assign w_clamped_n = (mem_rdata > 16'd64) ? 7'd64 : mem_rdata[6:0];
    assign w_last      = ((r_i + 7'd1) == r_n);
    assign w_differ    = (mem_rdata != r_my_cl);
    assign w_full      = (r_k == 5'd16);

    assign match_count = r_k;
    assign overflow    = r_overflow;
    assign dbg_state   = r_state;

    always_comb begin
        w_next    = r_state;
        mem_addr  = 16'd0;
        mem_wr_en = 1'b0;
        mem_wdata = 16'd0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_RD_NCOUNT;
            end
            S_RD_NCOUNT: begin
                mem_addr = NB_COUNT_ADDR;
                w_next   = (w_clamped_n == 7'd0) ? S_WR_COUNT : S_RD_NID;
            end
            S_RD_NID: begin
                mem_addr = NB_ID_BASE + {8'd0, r_i, 1'b0};
                w_next   = S_RD_CID;
            end
            S_RD_CID: begin
                mem_addr = CL_ID_BASE + {8'd0, r_i, 1'b0};
                if (w_differ && !w_full) w_next = S_WR_ENTRY;
                else                     w_next = w_last ? S_WR_COUNT : S_RD_NID;
            end
            S_WR_ENTRY: begin
                mem_addr  = OUT_BASE + {10'd0, r_k, 1'b0};
                mem_wdata = r_id;
                // A reset landing on a write cycle must not let that write commit.
                mem_wr_en = !reset;
                w_next    = w_last ? S_WR_COUNT : S_RD_NID;
            end
            S_WR_COUNT: begin
                mem_addr  = OUT_COUNT_ADDR;
                mem_wdata = {11'd0, r_k};
                mem_wr_en = !reset;
                w_next    = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_my_cl    <= 16'd0;
            r_id       <= 16'd0;
            r_n        <= 7'd0;
            r_i        <= 7'd0;
            r_k        <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_my_cl    <= my_cluster_id;
                        r_k        <= 5'd0;
                        r_overflow <= 1'b0;
                        r_i        <= 7'd0;
                    end
                end
                S_RD_NCOUNT: r_n  <= w_clamped_n;
                S_RD_NID:    r_id <= mem_rdata;
                S_RD_CID: begin
                    if (w_differ && w_full) r_overflow <= 1'b1;
                    // When heading to WR_ENTRY the index advances there instead.
                    if (!(w_differ && !w_full)) r_i <= r_i + 7'd1;
                end
                S_WR_ENTRY: begin
                    r_k <= r_k + 5'd1;
                    r_i <= r_i + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_cluster_scanner.sv
module tb_neighbor_cluster_scanner;

    localparam int NB_COUNT_ADDR  = 'h68A;
    localparam int NB_ID_BASE     = 'h48;
    localparam int CL_ID_BASE     = 'hC8;
    localparam int OUT_BASE       = 'h668;
    localparam int OUT_COUNT_ADDR = 'h68C;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] my_cluster_id;
    logic [15:0] mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [4:0]  match_count;
    logic        overflow;
    logic [2:0]  dbg_state;

    neighbor_cluster_scanner dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .my_cluster_id (my_cluster_id),
        .mem_addr      (mem_addr),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .match_count   (match_count),
        .overflow      (overflow),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [7:0] mem     [0:2047];
    logic [7:0] img     [0:2047];
    logic [7:0] exp_img [0:2047];
    logic       load_req = 1'b0;
    int         wr_cnt = 0;

    assign mem_rdata = {mem[mem_addr[10:0]], mem[mem_addr[10:0] + 11'd1]};

    always @(posedge clock) begin
        if (load_req) begin
            for (int j = 0; j < 2048; j++) mem[j] <= img[j];
        end else if (mem_wr_en) begin
            mem[mem_addr[10:0]]         <= mem_wdata[15:8];
            mem[mem_addr[10:0] + 11'd1] <= mem_wdata[7:0];
            wr_cnt <= wr_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_aq[$];
    logic [15:0] exp_dq[$];
    int          m_n;
    int          m_k;
    logic        m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] img_w(input int a);
        return {img[a], img[a + 1]};
    endfunction

    function automatic logic [15:0] mem_w(input int a);
        return {mem[a], mem[a + 1]};
    endfunction

    task automatic set_w(input int a, input logic [15:0] v);
        img[a]     = v[15:8];
        img[a + 1] = v[7:0];
    endtask

    // Reference: walk the table as the algorithm describes, producing the
    // ordered list of expected writes and the resulting memory image.
    task automatic model(input logic [15:0] cl, input int n_apply);
        int          k;
        logic [15:0] id;
        logic [15:0] c;
        exp_aq.delete();
        exp_dq.delete();
        m_n = int'(img_w(NB_COUNT_ADDR));
        if (m_n > 64) m_n = 64;
        k = 0;
        m_ov = 1'b0;
        for (int i = 0; i < m_n; i++) begin
            id = img_w(NB_ID_BASE + 2 * i);
            c  = img_w(CL_ID_BASE + 2 * i);
            if (c != cl) begin
                if (k < 16) begin
                    exp_aq.push_back(16'(OUT_BASE + 2 * k));
                    exp_dq.push_back(id);
                    k++;
                end else begin
                    m_ov = 1'b1;
                end
            end
        end
        exp_aq.push_back(16'(OUT_COUNT_ADDR));
        exp_dq.push_back(16'(k));
        m_k = k;
        for (int j = 0; j < 2048; j++) exp_img[j] = img[j];
        for (int w = 0; w < exp_aq.size() && w < n_apply; w++) begin
            exp_img[exp_aq[w]]     = exp_dq[w][15:8];
            exp_img[exp_aq[w] + 1] = exp_dq[w][7:0];
        end
    endtask

    task automatic compare_image(input string tag);
        int bad;
        bad = 0;
        for (int j = 0; j < 2048; j++) if (mem[j] !== exp_img[j]) bad++;
        check(tag, bad, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_mem();
        load_req = 1'b1;
        @(posedge clock);
        #1 load_req = 1'b0;
    endtask

    task automatic fill_random(input logic [15:0] cnt);
        for (int j = 0; j < 2048; j++) img[j] = 8'($urandom);
        for (int i = 0; i < 64; i++) set_w(CL_ID_BASE + 2 * i, 16'($urandom_range(0, 3)));
        set_w(NB_COUNT_ADDR, cnt);
    endtask

    // Runs one scan from the IDLE cycle; returns the done cycle number
    // (start cycle = 0) and the highest table-read address seen.
    task automatic run_scan(input string tag, input logic [15:0] cl, input bit pulse_mid,
                            output int t, output logic [15:0] mx);
        int w0;
        model(cl, 1000);
        @(negedge clock);
        check({tag, "_idle_busy"}, busy, 1'b0);
        start = 1'b1;
        my_cluster_id = cl;
        w0 = wr_cnt;
        @(negedge clock);
        start = 1'b0;
        my_cluster_id = 16'($urandom);
        check({tag, "_accept_busy"}, busy, 1'b1);
        mx = 16'd0;
        t = 1;
        while (!done && t < 3000) begin
            if ((dbg_state == 3'd2 || dbg_state == 3'd3) && mem_addr > mx) mx = mem_addr;
            if (pulse_mid) begin
                if (t == 5) start = 1'b1;
                else if (t == 6) start = 1'b0;
            end
            @(negedge clock);
            t++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_done_cycle"}, t, 3 + 2 * m_n + m_k);
        check({tag, "_match_count"}, match_count, m_k);
        check({tag, "_overflow"}, overflow, m_ov);
        check({tag, "_write_count"}, wr_cnt - w0, m_k + 1);
        compare_image({tag, "_image"});
    endtask

    // ---------------- stimulus ----------------
    int          t;
    logic [15:0] mx;
    int          w0;
    int          guard;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        my_cluster_id = 16'd0;
        for (int j = 0; j < 2048; j++) img[j] = 8'd0;
        load_mem();
        @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_match_count", match_count, 5'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 16'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        reset = 1'b0;

        // Directed example table.
        fill_random(16'd4);
        set_w(NB_ID_BASE + 0, 16'd3);  set_w(CL_ID_BASE + 0, 16'd1);
        set_w(NB_ID_BASE + 2, 16'd1);  set_w(CL_ID_BASE + 2, 16'd1);
        set_w(NB_ID_BASE + 4, 16'd10); set_w(CL_ID_BASE + 4, 16'd2);
        set_w(NB_ID_BASE + 6, 16'd6);  set_w(CL_ID_BASE + 6, 16'd3);
        load_mem();
        run_scan("ex", 16'd1, 1'b0, t, mx);
        check("ex_entry0", mem_w('h668), 16'h000A);
        check("ex_entry1", mem_w('h66A), 16'h0006);
        check("ex_count_word", mem_w('h68C), 16'h0002);
        check("ex_cycle13", t, 13);
        check("ex_mc2", match_count, 5'd2);

        // Empty neighbor list.
        fill_random(16'd0);
        load_mem();
        run_scan("zero", 16'd2, 1'b0, t, mx);
        check("zero_cycle3", t, 3);
        check("zero_count_word", mem_w('h68C), 16'h0000);

        // Overflowing list: 20 neighbors, none in own cluster.
        fill_random(16'd20);
        for (int i = 0; i < 64; i++) set_w(CL_ID_BASE + 2 * i, 16'h0007);
        load_mem();
        run_scan("ovf", 16'h0005, 1'b0, t, mx);
        check("ovf_cycle59", t, 59);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_count_word", mem_w('h68C), 16'd16);

        // Clamped count.
        fill_random(16'd200);
        load_mem();
        run_scan("clamp", 16'd1, 1'b0, t, mx);
        check("clamp_max_read", mx, 16'h0146);

        // start pulsed mid-scan must be ignored; next scan is back-to-back.
        fill_random(16'd30);
        load_mem();
        run_scan("pulse", 16'd0, 1'b1, t, mx);
        run_scan("b2b", 16'd3, 1'b0, t, mx);

        // Reset during the second WR_ENTRY.
        fill_random(16'd10);
        for (int i = 0; i < 64; i++) set_w(CL_ID_BASE + 2 * i, 16'h0009);
        load_mem();
        model(16'd1, 1);
        @(negedge clock);
        start = 1'b1;
        my_cluster_id = 16'd1;
        w0 = wr_cnt;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(mem_wr_en && mem_addr == 16'(OUT_BASE + 2)) && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        check("rstmid_found", guard < 500, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_wr_en", mem_wr_en, 1'b0);
        check("rstmid_writes", wr_cnt - w0, 1);
        compare_image("rstmid_image");
        run_scan("rerun", 16'd1, 1'b0, t, mx);

        // Randomized scans against the reference model.
        for (int r = 0; r < 8; r++) begin
            fill_random((r == 3) ? 16'($urandom_range(65, 65535)) : 16'($urandom_range(0, 70)));
            load_mem();
            run_scan($sformatf("rand%0d", r), 16'($urandom_range(0, 3)), 1'b0, t, mx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neighbor_cluster_scanner.md
# neighbor_cluster_scanner

Bus initiator for the 2048-byte node table memory. On `start`, it reads the neighbor count and each neighbor's ID and cluster ID. Every neighbor whose cluster differs from the node's own cluster is written into the betterneighbors list, and the match count is written to betterneighborCount. It drives the memory's single port: byte address, 16-bit big-endian word, combinational read, write on clock edge.

## Interface
- `NB_COUNT_ADDR`, 'h68A: neighborCount word address
- `NB_ID_BASE`, 'h48: neighborID[0] address; entry i is at base+2i
- `CL_ID_BASE`, 'hC8: clusterID[0] address; entry i is at base+2i
- `OUT_BASE`, 'h668: betterneighbors[0] address; entry k is at base+2k
- `OUT_COUNT_ADDR`, 'h68C: betterneighborCount word address
- `MAX_NEIGHBORS`, 64: clamp applied to the neighbor count read from memory
- `MAX_OUT`, 16: capacity of the betterneighbors list

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: scan request, sampled only in IDLE
- `my_cluster_id` in 16: own cluster ID, latched when `start` is accepted
- `mem_addr` out 16: byte address to memory
- `mem_wr_en` out 1: memory write enable
- `mem_wdata` out 16: write word (to memory data_in)
- `mem_rdata` in 16: read word (from memory data_out), valid in the same cycle as `mem_addr`
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle
- `done` out 1: one-cycle pulse at the end of a scan
- `match_count` out 5: number of entries written by the last scan (0..16)
- `overflow` out 1: a match was dropped because the list was full

## Operation
- States: IDLE, RD_NCOUNT, RD_NID, RD_CID, WR_ENTRY, WR_COUNT, DONE.
- IDLE
  - With `start`=1: latch `my_cluster_id`, clear `match_count`, `overflow`, index i and k, then go to RD_NCOUNT.
  - With `start`=0: stay.
- RD_NCOUNT
  - Drive `mem_addr`=NB_COUNT_ADDR.
  - At the edge, capture N = min(`mem_rdata`, MAX_NEIGHBORS).
  - If N==0, go to WR_COUNT; otherwise go to RD_NID.
- RD_NID: drive `mem_addr`=NB_ID_BASE+2i. Capture the ID and go to RD_CID.
- RD_CID: drive `mem_addr`=CL_ID_BASE+2i and compare `mem_rdata` against the latched cluster.
  - Differ and k<MAX_OUT: go to WR_ENTRY.
  - Differ and k==MAX_OUT: set `overflow`, then advance.
  - Equal: advance.
- WR_ENTRY
  - Drive `mem_addr`=OUT_BASE+2k, `mem_wdata`=captured ID, `mem_wr_en`=1.
  - Increment k, then advance.
- Advance: i←i+1. If i+1==N, go to WR_COUNT; otherwise go to RD_NID.
- WR_COUNT: drive `mem_addr`=OUT_COUNT_ADDR, `mem_wdata`={11'b0,k}, `mem_wr_en`=1. Then go to DONE.
- DONE: `done`=1. Go to IDLE.
- Address arithmetic is 16-bit unsigned; 2i and 2k are a left shift.
- `mem_wr_en`=1 only in WR_ENTRY and WR_COUNT.
- `mem_wdata`=0 and `mem_addr`=0 in IDLE and DONE.
- `match_count` tracks k live and holds its final value until the next accepted `start`. `overflow` likewise holds until the next accepted `start`.
- `start` while busy is ignored; no queuing.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `match_count` 0, `overflow` 0, `mem_wr_en` 0, `mem_addr` 0, `mem_wdata` 0.
- Reset mid-scan: go to IDLE at that edge, with no write on that edge. Entries already written stay in memory; betterneighborCount is not updated.
- Memory port outputs are decoded from the current state and registered indices. Reads are sampled at the rising edge that ends the state; each write commits at the rising edge that ends its state.
- Cycle numbering, with `start` high in IDLE at cycle 0:
  - RD_NCOUNT is cycle 1.
  - Each neighbor takes 2 cycles, plus 1 if it is written.
  - WR_COUNT is cycle 2+2N+M, where M is the number of entries written.
  - DONE/`done` is cycle 3+2N+M.
  - IDLE is cycle 4+2N+M; `start` may be accepted in that cycle.
- N==0: WR_COUNT at cycle 2, `done` at cycle 3, count written as 0.

## Test plan
- Memory: count=4, IDs {3,1,10,6}, clusters {1,1,2,3}; `my_cluster_id`=1.
  - 'h668..'h66B = 00,0A,00,06; 'h68C/D = 0x0002.
  - `match_count`=2, `done` at cycle 13, `overflow`=0.
- Count=0 → only a write of 0x0000 to 'h68C; `done` at cycle 3; no other write.
- Count=20, all clusters ≠ own → 16 entries written, count word 16, `overflow`=1, `done` at cycle 3+40+16=59.
- Count=200 → clamped to 64; the last read is at 'hC8+126; no address beyond 'h147 is read.
- `start` pulsed during a scan → ignored; results identical to a single scan. Back-to-back `start` in cycle 4+2N+M → accepted.
- `reset` asserted during the second WR_ENTRY → no write that cycle; `busy`, `done`, `mem_wr_en` all 0 next cycle. Rerun after reset → correct results.
